sd_spi_byte_xfer: RTL and testbench
===================================

Name: sd_spi_byte_xfer

Overview:
SPI mode-0 byte transceiver for the SD-card path, directly downstream of the SD clock divider. It runs on the divider's output clock (slow during card init, fast afterwards), so SPI rate follows divider state with no retiming. It shifts one byte out on MOSI while shifting one in from MISO, and drives SCLK at half its input clock rate. The SD command/init sequencer drives it with a Start/Done handshake.

Parameters:
NBITS, 8, bits per transfer (fixed 8 for SD; bit counter sized from it)
MOSI_IDLE, 1'b1, MOSI level when not transferring (SD requires high)
MSB_FIRST, 1, 1 = shift MSB first (SD), 0 = LSB first

Ports:
CLKin  in  1  transfer clock = divider CLKout; all logic on posedge
Reset  in  1  asynchronous, active-low reset (0 = reset)
Start  in  1  request a transfer; sampled only in IDLE
TxData  in  8  byte to send; captured on the accepting edge
MISO  in  1  serial data from card
SCLK  out  1  SPI clock, idle low (registered)
MOSI  out  1  serial data to card (registered)
RxData  out  8  last received byte; held until next Done
Busy  out  1  high while state != IDLE
Done  out  1  one-cycle pulse, RxData valid

Behaviour:
- Reset (Reset=0, async): state IDLE, SCLK=0, MOSI=MOSI_IDLE, RxData=0, Busy=0, Done=0, bit count=0, shift regs=0.
- States: IDLE, LOW, HIGH, DONE. All outputs registered.
- IDLE: Start=1 at edge E0 -> load tx shift reg from TxData, MOSI=first bit, SCLK=0, bit count=0, Busy=1, go LOW. Start=0 -> stay.
- LOW -> HIGH (edge E2i+1): SCLK=1, capture MISO into rx shift reg (MISO stable since previous falling edge).
- HIGH -> LOW (edge E2i+2, i<7): SCLK=0, MOSI=next bit, count+1.
- HIGH -> DONE (edge E16, bit 7 sampled at E15): SCLK=0, MOSI=MOSI_IDLE, RxData=rx shift reg, Done=1.
- DONE -> IDLE (E17): Done=0, Busy=0.
- Latency: 16 SCLK half-periods; Done visible E16-E17; back-to-back Start held high accepted at E18 (18 cycles/byte).
- Start while Busy (incl. DONE) ignored; TxData changes after E0 have no effect.
- MSB_FIRST=0: bit 0 first on MOSI; received bits fill from bit 7 down (first received bit lands in RxData[0]).
- Async reset mid-transfer aborts immediately to reset values; no Done; RxData cleared.
- SCLK never glitches: changes only on state transitions, idle low outside LOW/HIGH.

Optional Feature:
SD_SPI_CRC7_EN: adds input CrcClr (1 bit) and output Crc7 (7 bits). Running CRC7 (poly x^7+x^3+1) over every transmitted bit, updated on each HIGH->LOW/HIGH->DONE edge with the bit just sent; CrcClr=1 zeroes it synchronously (priority over update); reset zeroes it. Sequencer appends {Crc7,1'b1} as command byte 6. Without macro: ports and logic absent; sequencer uses constant CRCs.

Test Plan:
- MISO tied to MOSI, Start with TxData=8'hA5 at E0 -> MOSI bits 1,0,1,0,0,1,0,1; Done=1 exactly at E16; RxData=8'hA5; Busy low after E17.
- MISO=1 constant, TxData=8'h40 -> 8 SCLK rising edges, MOSI pattern 0,1,0,0,0,0,0,0; RxData=8'hFF; MOSI returns to 1 at E16.
- Start pulsed at E5 and at E16 during transfer -> ignored; exactly one Done; RxData unchanged by extra pulses.
- Start held high continuously, TxData=8'h00 then 8'hFF -> second transfer begins at E18; two Done pulses 18 cycles apart.
- Reset driven low between edges E7 and E8 -> SCLK=0, MOSI=1, Busy=0, RxData=0 immediately; no Done; next Start operates normally.
- SD_SPI_CRC7_EN: CrcClr, then send 8'h40,8'h00,8'h00,8'h00,8'h00 -> Crc7=7'h4A (CMD0 CRC byte 8'h95).

Source files
------------

// File: rtl/sd_spi_byte_xfer.sv
// sd_spi_byte_xfer
// SPI mode-0 byte transceiver for the SD-card path. Runs directly on the SD
// clock divider output, so the SPI bit rate tracks the divider setting. One
// byte is shifted out on MOSI while one is shifted in from MISO; SCLK runs at
// half the CLKin rate and idles low. A transfer takes 16 CLKin edges from the
// accepting edge to the Done pulse, 18 edges back-to-back.
//
// Ports
//   CLKin   in   transfer clock (divider CLKout), all logic on posedge
//   Reset   in   asynchronous active-low reset
//   Start   in   transfer request, sampled only while idle
//   TxData  in   byte to send, captured on the accepting edge
//   MISO    in   serial data from card, sampled on SCLK rising edges
//   SCLK    out  SPI clock, idle low
//   MOSI    out  serial data to card, MOSI_IDLE when not transferring
//   RxData  out  last received byte, held until the next Done
//   Busy    out  high from the accepting edge until the return to idle
//   Done    out  one-cycle pulse, RxData valid
//
// Optional feature (define SD_SPI_CRC7_EN):
//   CrcClr  in   synchronous clear of the running CRC7 (wins over update)
//   Crc7    out  running CRC7 (x^7 + x^3 + 1) over every transmitted bit

module sd_spi_byte_xfer #(
  parameter int unsigned NBITS     = 8,
  parameter logic        MOSI_IDLE = 1'b1,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             CLKin,
  input  logic             Reset,
  input  logic             Start,
  input  logic [NBITS-1:0] TxData,
  input  logic             MISO,
`ifdef SD_SPI_CRC7_EN
  input  logic             CrcClr,
  output logic [6:0]       Crc7,
`endif
  output logic             SCLK,
  output logic             MOSI,
  output logic [NBITS-1:0] RxData,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NBITS-1:0] tx_q, tx_d;
  logic [NBITS-1:0] rx_q, rx_d;
  logic [NBITS-1:0] rx_data_q, rx_data_d;

  // Bit that goes on the wire next from a transmit shift register.
  function automatic logic tx_head(input logic [NBITS-1:0] d);
    return (MSB_FIRST != 0) ? d[NBITS-1] : d[0];
  endfunction

  // Drop the bit just sent.
  function automatic logic [NBITS-1:0] tx_shift(input logic [NBITS-1:0] d);
    return (MSB_FIRST != 0) ? (d << 1) : (d >> 1);
  endfunction

  // LSB-first fills from the top so the first received bit ends in bit 0.
  function automatic logic [NBITS-1:0] rx_shift(input logic [NBITS-1:0] d,
                                                input logic             b);
    return (MSB_FIRST != 0) ? {d[NBITS-2:0], b} : {b, d[NBITS-1:1]};
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_LOW;
          tx_d    = TxData;
          rx_d    = '0;
          mosi_d  = tx_head(TxData);
          sclk_d  = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_LOW: begin
        // MISO has been stable since the previous falling edge.
        state_d = S_HIGH;
        sclk_d  = 1'b1;
        rx_d    = rx_shift(rx_q, MISO);
      end
      S_HIGH: begin
        sclk_d = 1'b0;
        if (cnt_q == LAST_BIT) begin
          state_d   = S_DONE;
          mosi_d    = MOSI_IDLE;
          rx_data_d = rx_q;
          done_d    = 1'b1;
        end else begin
          state_d = S_LOW;
          tx_d    = tx_shift(tx_q);
          mosi_d  = tx_head(tx_shift(tx_q));
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLKin or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      sclk_q    <= 1'b0;
      mosi_q    <= MOSI_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign SCLK   = sclk_q;
  assign MOSI   = mosi_q;
  assign Busy   = busy_q;
  assign Done   = done_q;
  assign RxData = rx_data_q;

`ifdef SD_SPI_CRC7_EN
  logic [6:0] crc_q, crc_d;
  logic       crc_fb;

  // Every HIGH phase ends on the next edge (to LOW or DONE), and the bit
  // being sent during that phase is the one currently on MOSI.
  always_comb begin
    crc_fb = crc_q[6] ^ mosi_q;
    crc_d  = crc_q;
    if (CrcClr) begin
      crc_d = '0;
    end else if (state_q == S_HIGH) begin
      crc_d = {crc_q[5:0], 1'b0} ^ ({7{crc_fb}} & 7'h09);
    end
  end

  // CRC register.
  always_ff @(posedge CLKin or negedge Reset) begin
    if (!Reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign Crc7 = crc_q;
`endif

endmodule

// File: tb/tb_sd_spi_byte_xfer.sv
// Bench for sd_spi_byte_xfer: a cycle-index model predicts SCLK/MOSI/Busy/
// Done/RxData every cycle; directed scenarios add hand-computed checks.
module tb_sd_spi_byte_xfer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       loop_mode = 1'b1;
  logic       miso_val = 1'b0;
  logic       miso;
  logic       sclk, mosi, busy, done;
  logic [7:0] rx_data;
`ifdef SD_SPI_CRC7_EN
  logic       crc_clr = 1'b0;
  logic [6:0] crc7;
`endif

  assign miso = loop_mode ? mosi : miso_val;

  always #5 clk = ~clk;

  sd_spi_byte_xfer dut (
    .CLKin  (clk),
    .Reset  (rst_n),
    .Start  (start),
    .TxData (tx_data),
    .MISO   (miso),
`ifdef SD_SPI_CRC7_EN
    .CrcClr (crc_clr),
    .Crc7   (crc7),
`endif
    .SCLK   (sclk),
    .MOSI   (mosi),
    .RxData (rx_data),
    .Busy   (busy),
    .Done   (done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: k counts edges since the accepting edge (-1 = idle).
  int         k = -1;
  logic [7:0] m_tx = 8'h00;
  logic [7:0] m_rx = 8'h00;
  logic [7:0] m_rxdata = 8'h00;
  logic       e_busy, e_done, e_sclk, e_mosi;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= -1;
      m_rxdata <= 8'h00;
    end else if (k < 0 || k >= 17) begin
      if (start) begin
        k    <= 0;
        m_tx <= tx_data;
      end else begin
        k <= -1;
      end
    end else begin
      k <= k + 1;
      // Edge E(k+1) is a rising SCLK edge when k is even: bit k/2, MSB first.
      if (k % 2 == 0) m_rx[3'(7 - k / 2)] <= miso;
      if (k == 15) m_rxdata <= m_rx;
    end
  end

  always_comb begin
    e_busy = (k >= 0 && k <= 16);
    e_done = (k == 16);
    e_sclk = (k >= 0 && k <= 15 && (k % 2) == 1);
    e_mosi = (k >= 0 && k <= 15) ? m_tx[3'(7 - k / 2)] : 1'b1;
  end

  // Per-cycle compare plus monitors for the directed scenarios.
  logic [7:0] mosi_cap = 8'h00;
  int         sclk_rises = 0;
  int         done_cnt = 0;
  int         last_done_cyc = 0;

  always @(negedge clk) begin
    chk("sclk", sclk, e_sclk);
    chk("mosi", mosi, e_mosi);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("rxdata", rx_data, m_rxdata);
    if (sclk) begin
      mosi_cap   <= {mosi_cap[6:0], mosi};
      sclk_rises <= sclk_rises + 1;
    end
    if (done) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Request at the current point; returns the cycle index of the accepting edge.
  task automatic begin_xfer(input logic [7:0] d, output int c0);
    start   = 1'b1;
    tx_data = d;
    tick();
    c0    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done_cnt != base) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int  c0, d0, r0, o, n, t1, t2;
    bit  ok;
    logic [7:0] rx1, rx2;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rxdata", rx_data, 8'h00);
    rst_n = 1'b1;
    tick();
    tick();

    // Loopback A5.
    loop_mode = 1'b1;
    d0 = done_cnt; r0 = sclk_rises;
    begin_xfer(8'hA5, c0);
    wait_done(d0, 40, ok);
    chk("a5_done_seen", ok, 1'b1);
    chk("a5_done_latency", last_done_cyc - c0, 16);
    chk("a5_rxdata", rx_data, 8'hA5);
    chk("a5_mosi_bits", mosi_cap, 8'hA5);
    chk("a5_sclk_rises", sclk_rises - r0, 8);
    tick();
    chk("a5_busy_after", busy, 1'b0);
    chk("a5_done_after", done, 1'b0);
    tick();

    // MISO held high, send 40.
    loop_mode = 1'b0; miso_val = 1'b1;
    d0 = done_cnt; r0 = sclk_rises;
    begin_xfer(8'h40, c0);
    wait_done(d0, 40, ok);
    chk("h40_done_seen", ok, 1'b1);
    chk("h40_done_latency", last_done_cyc - c0, 16);
    chk("h40_rxdata", rx_data, 8'hFF);
    chk("h40_mosi_bits", mosi_cap, 8'h40);
    chk("h40_sclk_rises", sclk_rises - r0, 8);
    chk("h40_mosi_idle", mosi, 1'b1);
    tick();
    tick();

    // Start pulses at E5 and E16 during a transfer are ignored.
    loop_mode = 1'b1;
    d0 = done_cnt;
    begin_xfer(8'h3C, c0);
    for (int i = 0; i < 40; i++) begin
      o = cyc - c0;
      start = (o == 4 || o == 15);
      if (o == 4) tx_data = 8'hFF;
      tick();
    end
    start = 1'b0;
    chk("ign_done_count", done_cnt - d0, 1);
    chk("ign_rxdata", rx_data, 8'h3C);

    // Start held high: back-to-back transfers 18 cycles apart.
    d0 = done_cnt;
    start = 1'b1; tx_data = 8'h00;
    tick();
    c0 = cyc;
    tx_data = 8'hFF;
    n = 0; t1 = -1; t2 = -1; rx1 = 8'hXX; rx2 = 8'hXX;
    for (int i = 0; i < 45; i++) begin
      o = cyc - c0;
      if (o >= 18) start = 1'b0;
      if (done) begin
        if (n == 0) begin t1 = o; rx1 = rx_data; end
        else begin t2 = o; rx2 = rx_data; end
        n++;
      end
      tick();
    end
    start = 1'b0;
    chk("b2b_done_count", n, 2);
    chk("b2b_first_done", t1, 16);
    chk("b2b_spacing", t2 - t1, 18);
    chk("b2b_rx_first", rx1, 8'h00);
    chk("b2b_rx_second", rx2, 8'hFF);
    chk("b2b_rx_held", rx_data, 8'hFF);

    // Reset between E7 and E8 aborts the transfer.
    d0 = done_cnt;
    begin_xfer(8'h5A, c0);
    while (cyc - c0 < 7) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("abort_sclk", sclk, 1'b0);
    chk("abort_mosi", mosi, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_rxdata", rx_data, 8'h00);
    tick();
    rst_n = 1'b1;
    repeat (25) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    begin_xfer(8'hC3, c0);
    wait_done(d0, 40, ok);
    chk("post_done_seen", ok, 1'b1);
    chk("post_done_latency", last_done_cyc - c0, 16);
    chk("post_rxdata", rx_data, 8'hC3);
    tick();
    tick();

`ifdef SD_SPI_CRC7_EN
    // CMD0 body 40 00 00 00 00 gives CRC7 4A.
    crc_clr = 1'b1;
    tick();
    crc_clr = 1'b0;
    chk("crc_cleared", crc7, 7'h00);
    for (int b = 0; b < 5; b++) begin
      d0 = done_cnt;
      begin_xfer((b == 0) ? 8'h40 : 8'h00, c0);
      wait_done(d0, 40, ok);
      chk("crc_done_seen", ok, 1'b1);
      tick();
    end
    chk("crc_cmd0", crc7, 7'h4A);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
